// File: rtl/proj_pkg.sv
// proj_pkg: shared direction/velocity types, arena bounds and lifetime table for the projectile pool
package proj_pkg;
  typedef enum logic [2:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef logic signed [3:0] vel_t;
  localparam logic [9:0] X_MIN = 10'd0, X_MAX = 10'd639, Y_MIN = 10'd16, Y_MAX = 10'd479;
  localparam int MAX_BOUNCE = 3;
  function automatic logic [10:0] life_frames(input logic [1:0] sel);
    return sel == 2'd0 ? 11'd300 : sel == 2'd1 ? 11'd600 : sel == 2'd2 ? 11'd900 : 11'd1200;
  endfunction
endpackage

// File: rtl/proj_slot.sv
// proj_slot: one projectile's position, velocity, age and wall/obstacle reflection; bounce cap under PROJ_BOUNCE_LIMIT_EN
module proj_slot
  import proj_pkg::*;
#(
  parameter int N_OBS   = 12,
  parameter int HALF_SZ = 2
) (
  input  logic                frame_clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                spawn_i,
  input  logic                hit_i,
  input  logic [9:0]          spawn_x_i,
  input  logic [9:0]          spawn_y_i,
  input  logic [3:0]          spawn_vx_i,
  input  logic [3:0]          spawn_vy_i,
  input  logic [10:0]         life_i,
  input  logic [10*N_OBS-1:0] obs_left_i,
  input  logic [10*N_OBS-1:0] obs_right_i,
  input  logic [9*N_OBS-1:0]  obs_top_i,
  input  logic [9*N_OBS-1:0]  obs_bottom_i,
  output logic [9:0]          x_o,
  output logic [9:0]          y_o,
  output logic                active_o
);
  localparam logic [10:0] H = 11'(HALF_SZ);
  logic [9:0] x_q, x_d, y_q, y_d, nx, ny;
  vel_t vx_q, vx_d, vy_q, vy_d;
  logic [10:0] age_q, age_d, life_q, life_d;
  logic act_q, act_d, wall_x, wall_y, obs_hit, bounce, retire;
`ifdef PROJ_BOUNCE_LIMIT_EN
  logic [2:0] bcnt_q, bcnt_d;
  assign retire = hit_i || age_q >= life_q || (bounce && bcnt_q == 3'(MAX_BOUNCE));
`else
  assign retire = hit_i || age_q >= life_q;
`endif

  // candidate position and its wall / obstacle collisions (wrap below 0 lands above X_MAX)
  always_comb begin
    nx = x_q + {{6{vx_q[3]}}, vx_q};
    ny = y_q + {{6{vy_q[3]}}, vy_q};
    wall_x = nx <= X_MIN || nx >= X_MAX;
    wall_y = ny <= Y_MIN || ny >= Y_MAX;
    obs_hit = 1'b0;
    for (int i = 0; i < N_OBS; i++)
      obs_hit = obs_hit | (({1'b0, nx} < {1'b0, obs_right_i[10*i +: 10]} + H) &&
                           ({1'b0, nx} + H > {1'b0, obs_left_i[10*i +: 10]}) &&
                           ({1'b0, ny} < {2'b0, obs_bottom_i[9*i +: 9]} + H) &&
                           ({1'b0, ny} + H > {2'b0, obs_top_i[9*i +: 9]}));
    bounce = wall_x | wall_y | obs_hit;
  end

  // clear beats spawn beats retire; a bounce reflects each axis at most once and holds position
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    vx_d = vx_q;
    vy_d = vy_q;
    age_d = age_q;
    life_d = life_q;
    act_d = act_q;
`ifdef PROJ_BOUNCE_LIMIT_EN
    bcnt_d = bcnt_q;
`endif
    if (clear_i) act_d = 1'b0;
    else if (spawn_i) begin
      x_d = spawn_x_i;
      y_d = spawn_y_i;
      vx_d = spawn_vx_i;
      vy_d = spawn_vy_i;
      age_d = '0;
      life_d = life_i;
      act_d = 1'b1;
`ifdef PROJ_BOUNCE_LIMIT_EN
      bcnt_d = '0;
`endif
    end else if (act_q) begin
      if (retire) act_d = 1'b0;
      else begin
        age_d = age_q + 11'd1;
        if (bounce) begin
          vx_d = (wall_x || (obs_hit && vx_q != 0)) ? -vx_q : vx_q;
          vy_d = (wall_y || (obs_hit && vy_q != 0)) ? -vy_q : vy_q;
`ifdef PROJ_BOUNCE_LIMIT_EN
          bcnt_d = bcnt_q + 3'd1;
`endif
        end else begin
          x_d = nx;
          y_d = ny;
        end
      end
    end
  end

  // slot state register
  always_ff @(posedge frame_clk_i or posedge reset_i)
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
      vx_q <= '0;
      vy_q <= '0;
      age_q <= '0;
      life_q <= '0;
      act_q <= 1'b0;
`ifdef PROJ_BOUNCE_LIMIT_EN
      bcnt_q <= '0;
`endif
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
      age_q <= age_d;
      life_q <= life_d;
      act_q <= act_d;
`ifdef PROJ_BOUNCE_LIMIT_EN
      bcnt_q <= bcnt_d;
`endif
    end

  assign x_o = x_q;
  assign y_o = y_q;
  assign active_o = act_q;
endmodule

// File: rtl/projectile_pool.sv
// projectile_pool: fire edge detect, cooldown, free-slot allocation and N_PROJ slots; PROJ_BOUNCE_LIMIT_EN caps bounces
module projectile_pool
  import proj_pkg::*;
#(
  parameter int N_PROJ   = 5,
  parameter int N_OBS    = 12,
  parameter int SPEED    = 3,
  parameter int MUZZLE   = 20,
  parameter int HALF_SZ  = 2,
  parameter int COOLDOWN = 60
) (
  input  logic                 frame_clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 fire_req_i,
  input  logic                 fire_en_i,
  input  logic [2:0]           tank_dir_i,
  input  logic [9:0]           tank_x_i,
  input  logic [9:0]           tank_y_i,
  input  logic [1:0]           life_sel_i,
  input  logic [10*N_OBS-1:0]  obs_left_i,
  input  logic [10*N_OBS-1:0]  obs_right_i,
  input  logic [9*N_OBS-1:0]   obs_top_i,
  input  logic [9*N_OBS-1:0]   obs_bottom_i,
  input  logic [N_PROJ-1:0]    hit_kill_i,
  output logic [10*N_PROJ-1:0] proj_x_o,
  output logic [10*N_PROJ-1:0] proj_y_o,
  output logic [N_PROJ-1:0]    proj_active_o,
  output logic                 fire_ack_o,
  output logic [9:0]           proj_size_o
);
  logic fire_q, ack_q, accept, any_free;
  logic [15:0] cd_q, cd_d;
  logic [N_PROJ-1:0] sel;
  logic [9:0] sx, sy;
  vel_t svx, svy;

  // muzzle position and launch velocity along the tank heading
  always_comb begin
    sx = tank_dir_i == DIR_LEFT ? tank_x_i - 10'(MUZZLE) : tank_dir_i == DIR_RIGHT ? tank_x_i + 10'(MUZZLE) : tank_x_i;
    sy = tank_dir_i == DIR_UP ? tank_y_i - 10'(MUZZLE) : tank_dir_i == DIR_DOWN ? tank_y_i + 10'(MUZZLE) : tank_y_i;
    svx = tank_dir_i == DIR_LEFT ? -vel_t'(SPEED) : tank_dir_i == DIR_RIGHT ? vel_t'(SPEED) : vel_t'(0);
    svy = tank_dir_i == DIR_UP ? -vel_t'(SPEED) : tank_dir_i == DIR_DOWN ? vel_t'(SPEED) : vel_t'(0);
  end

  // lowest-index slot that is inactive now; a slot retiring this frame still reads active
  always_comb begin
    sel = '0;
    any_free = 1'b0;
    for (int i = 0; i < N_PROJ; i++)
      if (!proj_active_o[i] && !any_free) begin
        sel[i] = 1'b1;
        any_free = 1'b1;
      end
  end

  assign accept = fire_req_i && !fire_q && fire_en_i && cd_q == 16'd0 && tank_dir_i <= 3'd3 && !clear_i && any_free;
  assign cd_d = accept ? 16'(COOLDOWN) : cd_q != 16'd0 ? cd_q - 16'd1 : cd_q;

  // key history, cooldown and one-frame ack
  always_ff @(posedge frame_clk_i or posedge reset_i)
    if (reset_i) begin
      fire_q <= 1'b0;
      ack_q <= 1'b0;
      cd_q <= '0;
    end else begin
      fire_q <= fire_req_i;
      ack_q <= accept;
      cd_q <= cd_d;
    end

  assign fire_ack_o = ack_q;
  assign proj_size_o = 10'(HALF_SZ * 2);

  for (genvar i = 0; i < N_PROJ; i++) begin : g_slot
    proj_slot #(.N_OBS(N_OBS), .HALF_SZ(HALF_SZ)) u_slot (
      .frame_clk_i (frame_clk_i),
      .reset_i     (reset_i),
      .clear_i     (clear_i),
      .spawn_i     (accept && sel[i]),
      .hit_i       (hit_kill_i[i]),
      .spawn_x_i   (sx),
      .spawn_y_i   (sy),
      .spawn_vx_i  (svx),
      .spawn_vy_i  (svy),
      .life_i      (life_frames(life_sel_i)),
      .obs_left_i  (obs_left_i),
      .obs_right_i (obs_right_i),
      .obs_top_i   (obs_top_i),
      .obs_bottom_i(obs_bottom_i),
      .x_o         (proj_x_o[10*i +: 10]),
      .y_o         (proj_y_o[10*i +: 10]),
      .active_o    (proj_active_o[i])
    );
  end
endmodule
